uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver in the UART IP. It watches the receiver's busy flag and, at the end of every frame, captures the completed byte into a synchronous FIFO. Bytes leave through a first-word-fall-through valid/ready port towards the AXI register interface. It also provides a fill level, a threshold interrupt and a sticky overrun flag.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- AW, log2(DEPTH), pointer width (derived, not overridden)
- THRESH, 8, fill level at or above which rx_irq asserts; 1..DEPTH
- clk  in  1  system clock (PS 50 MHz domain, same clock as the receiver)
- rst  in  1  reset; one clock, synchronous, active-high
- rx_busy  in  1  receiver busy flag; high from start-bit detection through stop bit
- rx_data  in  8  receiver data byte; stable and complete when rx_busy falls
- m_valid  out  1  head byte available (= not empty)
- m_data  out  8  head byte; meaningful only while m_valid = 1
- m_ready  in  1  consumer accepts head byte when m_valid & m_ready
- level  out  AW+1  number of stored bytes, 0..DEPTH
- full  out  1  level == DEPTH
- rx_irq  out  1  level ≥ THRESH
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- ovr_clr  in  1  single-cycle clear of overrun

## Operation
- Frame detect: register busy_d <= rx_busy. frame_end = armed & busy_d & ~rx_busy.
- armed: cleared by reset. Set on the first cycle rx_busy is sampled low. Once set, it stays set until the next reset. This stops a frame that was already in progress at reset from being pushed as a partial byte.
- push = frame_end. pop = m_valid & m_ready.
- Storage: DEPTH×8 register array, write pointer wp and read pointer rp, each AW bits and wrapping modulo DEPTH. A separate level counter of AW+1 bits tracks occupancy.
- push & ~full: mem[wp] <= rx_data, wp++.
- push & full & ~pop: byte dropped, wp unchanged, overrun <= 1.
- push & full & pop: the pop frees a slot, the byte is written, and level is unchanged (no overrun).
- push & empty: only a push is possible (m_valid = 0), so level goes 0→1.
- pop: rp++, level--. level changes by +1, -1 or 0 per cycle.
- Overrun flag: ovr_clr clears it. If a set condition occurs in the same cycle as ovr_clr, the set wins.
- Output decode: m_data = mem[rp] (FWFT). m_valid = (level != 0), full, and rx_irq are all combinational decodes of level.

## Timing
- Reset values: m_valid 0, level 0, full 0, rx_irq 0, overrun 0, m_data don't-care (mem not reset), wp = rp = 0, busy_d 0, armed 0.
- Reset mid-operation discards all contents and the overrun flag on the next clock edge.
- Push latency: rx_busy falls in cycle N. frame_end is asserted in cycle N (rx_busy combinational, busy_d registered). The write takes effect at the end of N, so m_valid/level update in N+1.
- Pop: a handshake in cycle N makes the next byte or m_valid = 0 visible in N+1. Back-to-back pops at one per cycle are allowed.
- Handshake: m_data is stable while m_valid & ~m_ready. m_valid never deasserts without a pop or reset.
- Frame spacing is ≥ 10 bit times (~4340 clk at 434 clk/bit), so push never occurs on consecutive cycles. The FIFO must still be correct if it does.

## Structure
- uart_pkg holds UART_DATA_W = 8 and CLKS_PER_BIT = 434, which the receiver and transmitter share.
- One sub-module, uart_sync_fifo: parameterised storage, pointers, level, and FWFT read with push/pop ports. It contains no UART knowledge.
- uart_rx_fifo contains only edge detect, arming, overrun and the irq decode.

## Test plan
- Reset, then three frames 0x41, 0x42, 0x43 with m_ready = 0 → level = 3, m_valid = 1, m_data = 0x41. Then m_ready = 1 for 3 cycles → 0x41, 0x42, 0x43 in consecutive cycles, then m_valid = 0.
- Fill 16 frames 0x00..0x0F, then a 17th frame 0x99 → full = 1, overrun = 1, and the drained sequence is 0x00..0x0F with no 0x99. Pulse ovr_clr → overrun = 0.
- Full FIFO with pop in the exact cycle rx_busy falls (data 0x5A) → level stays 16, overrun = 0, and 0x5A drains last.
- THRESH = 8: push 7 → rx_irq = 0. Push 8th → rx_irq = 1 in the following cycle. Pop 1 → rx_irq = 0.
- Assert rst while rx_busy = 1 mid-frame, then rx_busy falls → no push, level = 0. The next full frame 0x7E is pushed normally.
- Overrun set and ovr_clr in the same cycle → overrun = 1 afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART IP (receiver, transmitter and the
// receive-side byte buffer).
//   UART_DATA_W  : width of one UART character
//   CLKS_PER_BIT : system clocks per bit time at the configured baud rate
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_W  = 8;
   localparam int CLKS_PER_BIT = 434;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Generic single-clock first-word-fall-through FIFO. No UART knowledge.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write request (accepted when not full, or when full and a
//               read happens in the same cycle)
//   i_wdata   : write data
//   i_pop     : read request (ignored while empty)
//   o_rdata   : head entry, valid while o_empty = 0
//   o_level   : number of stored entries, 0..DEPTH
//   o_empty   : level == 0
//   o_full    : level == DEPTH
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [AW:0]      r_level;

   logic w_empty;
   logic w_full;
   logic w_rd;
   logic w_wr;

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == FULL_LVL);

   // A read only happens when something is stored; a write into a full
   // FIFO is allowed only when the same-cycle read frees the head slot.
   assign w_rd = i_pop & ~w_empty;
   assign w_wr = i_push & (~w_full | w_rd);

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else begin
         if (w_wr) begin
            r_wp <= r_wp + 1'b1;
         end
         if (w_rd) begin
            r_rp <= r_rp + 1'b1;
         end
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage array; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wp] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[r_rp];
   assign o_level = r_level;
   assign o_empty = w_empty;
   assign o_full  = w_full;

endmodule : uart_sync_fifo

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer behind the UART receiver. Captures rx_data on
// every falling edge of rx_busy (end of frame) into a FWFT FIFO and presents
// bytes on a valid/ready port.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   rx_busy   : receiver busy flag (start bit through stop bit)
//   rx_data   : received byte, complete when rx_busy falls
//   m_valid   : head byte available
//   m_data    : head byte
//   m_ready   : consumer accepts head byte when m_valid & m_ready
//   level     : stored byte count, 0..DEPTH
//   full      : level == DEPTH
//   rx_irq    : level >= THRESH
//   overrun   : sticky, a byte was dropped because the FIFO was full
//   ovr_clr   : single-cycle clear of overrun (a same-cycle set wins)
// ---------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int THRESH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_busy,
   input  logic [UART_DATA_W-1:0]   rx_data,
   output logic                     m_valid,
   output logic [UART_DATA_W-1:0]   m_data,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     rx_irq,
   output logic                     overrun,
   input  logic                     ovr_clr
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] THRESH_LVL = (AW+1)'(THRESH);

   logic r_busy_d;
   logic r_armed;
   logic r_overrun;

   logic          w_frame_end;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;
   logic          w_ovr_set;
   logic [AW:0]   w_level;
   uart_byte_t    w_head;

   // armed keeps a frame already in progress at reset from being captured
   // as a partial byte: only falling edges seen after an idle sample count.
   assign w_frame_end = r_armed & r_busy_d & ~rx_busy;
   assign w_pop       = m_valid & m_ready;
   assign w_ovr_set   = w_frame_end & w_full & ~w_pop;

   // Edge detect, arming and sticky overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy_d  <= 1'b0;
         r_armed   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_busy_d <= rx_busy;
         r_armed  <= r_armed | ~rx_busy;
         if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end else if (ovr_clr) begin
            r_overrun <= 1'b0;
         end else begin
            r_overrun <= r_overrun;
         end
      end
   end

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_frame_end),
      .i_wdata (rx_data),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_level (w_level),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign m_valid = ~w_empty;
   assign m_data  = w_head;
   assign level   = w_level;
   assign full    = w_full;
   assign rx_irq  = (w_level >= THRESH_LVL);
   assign overrun = r_overrun;

endmodule : uart_rx_fifo
